// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock sequencer.
// The state enum is also exported on the debug port of the top level.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PRST      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_seq_state_e;

    localparam int LOSS_CNT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Flops clear on synchronous active-low reset.
module sync_ff #(
    parameter int Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/recovery sequencer: pulses PLL reset, waits for a stable lock with
// timeout and bounded retries, then releases the downstream reset; restarts on lock loss.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int ResetCycles       = 16,
    parameter int LockTimeoutCycles = 4096,
    parameter int StableCycles      = 256,
    parameter int MaxRetries        = 3,
    parameter int SyncStages        = 2,
    localparam int RetryW           = $clog2(MaxRetries + 1)
) (
    input  logic                  ref_clk,
    input  logic                  rst_n,
    input  logic                  pll_lock,
    input  logic                  restart,
    output logic                  pll_rst,
    output logic                  sys_rst_n,
    output logic                  locked,
    output logic                  fault,
    output logic [RetryW-1:0]     retry_cnt,
    output logic [LOSS_CNT_W-1:0] loss_cnt,
    output pll_seq_state_e        state_dbg
);

    localparam int CntMax = max3(ResetCycles, LockTimeoutCycles, StableCycles);
    localparam int CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0]   ResetLast   = CntW'(ResetCycles - 1);
    localparam logic [CntW-1:0]   TimeoutLast = CntW'(LockTimeoutCycles - 1);
    localparam logic [CntW-1:0]   StableLast  = CntW'(StableCycles - 1);
    localparam logic [RetryW-1:0] RetryLimit  = RetryW'(MaxRetries);

    pll_seq_state_e        state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [RetryW-1:0]     retry_q, retry_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  pll_rst_q, sys_rst_n_q, locked_q, fault_q;
    logic                  lock_s;

    sync_ff #(.Stages(SyncStages)) u_lock_sync (
        .clk_i  (ref_clk),
        .rst_ni (rst_n),
        .d_i    (pll_lock),
        .q_o    (lock_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            PRST: begin
                if (cnt_q == ResetLast) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    retry_d = retry_q + RetryW'(1);
                    state_d = (retry_d == RetryLimit) ? FAULT : PRST;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            STABLE: begin
                // A lock glitch sends us back to wait without spending a retry.
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d = PRST;
                    cnt_d   = '0;
                    if (loss_q != '1) begin
                        loss_d = loss_q + LOSS_CNT_W'(1);
                    end
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = PRST;
                cnt_d   = '0;
            end
        endcase
        if (restart) begin
            state_d = PRST;
            cnt_d   = '0;
            retry_d = '0;
        end
    end

    // Outputs decode the next state so they change on the same edge as the FSM.
    always_ff @(posedge ref_clk) begin
        if (!rst_n) begin
            state_q     <= PRST;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= (state_d == PRST) || (state_d == FAULT);
            sys_rst_n_q <= (state_d == RUN);
            locked_q    <= (state_d == RUN);
            fault_q     <= (state_d == FAULT);
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign locked    = locked_q;
    assign fault     = fault_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench: table-driven lock/loss sequence, hand-written corner sequences,
// and randomized asynchronous lock stimulus checked cycle-by-cycle against a reference model.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  localparam int R    = 4;
  localparam int T    = 20;
  localparam int S    = 8;
  localparam int MAXR = 3;
  localparam int SYNC = 2;
  localparam int RW   = $clog2(MAXR + 1);

  // clock / reset
  logic ref_clk  = 1'b0;
  logic rst_n    = 1'b0;
  logic pll_lock = 1'b0;
  logic restart  = 1'b0;
  always #5 ref_clk = ~ref_clk;

  logic           pll_rst, sys_rst_n, locked, fault;
  logic [RW-1:0]  retry_cnt;
  logic [7:0]     loss_cnt;
  pll_seq_state_e state_dbg;

  pll_lock_sequencer #(
    .ResetCycles      (R),
    .LockTimeoutCycles(T),
    .StableCycles     (S),
    .MaxRetries       (MAXR),
    .SyncStages       (SYNC)
  ) dut (
    .ref_clk  (ref_clk),
    .rst_n    (rst_n),
    .pll_lock (pll_lock),
    .restart  (restart),
    .pll_rst  (pll_rst),
    .sys_rst_n(sys_rst_n),
    .locked   (locked),
    .fault    (fault),
    .retry_cnt(retry_cnt),
    .loss_cnt (loss_cnt),
    .state_dbg(state_dbg)
  );

  int compared   = 0;
  int mismatched = 0;
  bit model_en   = 1'b0;

  // reference model: phases with elapsed-cycle counts, synchronizer as a sample queue
  localparam int M_PRST = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_FAULT = 4;
  int   m_phase = M_PRST;
  int   m_el    = 0;
  int   m_retry = 0;
  int   m_loss  = 0;
  logic m_sync_q[$];

  always @(posedge ref_clk) begin
    logic ls;
    ls = (m_sync_q.size() >= SYNC) ? m_sync_q.pop_front() : 1'b0;
    m_sync_q.push_back(pll_lock);
    if (!rst_n) begin
      m_phase = M_PRST; m_el = 0; m_retry = 0; m_loss = 0;
      m_sync_q.delete();
      for (int i = 0; i < SYNC; i++) m_sync_q.push_back(1'b0);
    end else if (restart) begin
      m_phase = M_PRST; m_el = 0; m_retry = 0;
    end else begin
      case (m_phase)
        M_PRST: begin
          m_el++;
          if (m_el == R) begin m_phase = M_WAIT; m_el = 0; end
        end
        M_WAIT: begin
          if (ls) begin
            m_phase = M_STAB; m_el = 0;
          end else begin
            m_el++;
            if (m_el == T) begin
              m_retry++;
              m_phase = (m_retry == MAXR) ? M_FAULT : M_PRST;
              m_el = 0;
            end
          end
        end
        M_STAB: begin
          if (!ls) begin
            m_phase = M_WAIT; m_el = 0;
          end else begin
            m_el++;
            if (m_el == S) begin m_phase = M_RUN; m_el = 0; end
          end
        end
        M_RUN: begin
          if (!ls) begin
            m_phase = M_PRST; m_el = 0;
            if (m_loss < 255) m_loss++;
          end
        end
        default: ;
      endcase
    end
  end

  // scoreboard: one expected output word per cycle, compared at negedge
  logic [13:0] exp_q[$];
  always @(negedge ref_clk) begin
    logic [13:0] dut_v, mdl_v;
    if (model_en) begin
      exp_q.push_back({(m_phase == M_PRST) || (m_phase == M_FAULT), m_phase == M_RUN,
                       m_phase == M_RUN, m_phase == M_FAULT, RW'(m_retry), 8'(m_loss)});
      mdl_v = exp_q.pop_front();
      dut_v = {pll_rst, sys_rst_n, locked, fault, retry_cnt, loss_cnt};
      compared++;
      if (dut_v !== mdl_v) begin
        mismatched++;
        $display("FAIL model t=%0t got %b want %b (pll_rst,sys_rst_n,locked,fault,retry,loss)",
                 $time, dut_v, mdl_v);
      end
    end
  end

  // driver / check tasks
  task automatic step(input int n);
    repeat (n) @(negedge ref_clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s t=%0t got %0d want %0d", name, $time, got, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic e_prst, input logic e_sys,
                          input logic e_lk, input logic e_f, input int e_r, input int e_l);
    chk({name, ".pll_rst"}, 32'(pll_rst), 32'(e_prst));
    chk({name, ".sys_rst_n"}, 32'(sys_rst_n), 32'(e_sys));
    chk({name, ".locked"}, 32'(locked), 32'(e_lk));
    chk({name, ".fault"}, 32'(fault), 32'(e_f));
    chk({name, ".retry_cnt"}, 32'(retry_cnt), 32'(e_r));
    chk({name, ".loss_cnt"}, 32'(loss_cnt), 32'(e_l));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; restart = 1'b0;
    step(3);
    model_en = 1'b1;
    chk_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b1;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step(1);
    restart = 1'b0;
  endtask

  task automatic wait_sys(input logic v, input int budget);
    int n;
    n = 0;
    while (sys_rst_n !== v && n < budget) begin step(1); n++; end
    compared++;
    if (sys_rst_n !== v) begin
      mismatched++;
      $display("FAIL wait_sys t=%0t got %b want %b within %0d cycles", $time, sys_rst_n, v, budget);
    end
  endtask

  typedef struct {
    logic rst_n; logic restart; logic lock; int cycles;
    logic e_prst; logic e_sys; logic e_lk; logic e_f; int e_r; int e_l;
  } vec_t;
  vec_t vecs[12];

  initial begin
    #1_000_000;
    mismatched++;
    $display("FAIL watchdog t=%0t bench did not complete", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    // clean lock, loss in RUN, relock (cycle counts measured from reset release)
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1};

    step(1);
    pll_lock = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      rst_n = vecs[i].rst_n; restart = vecs[i].restart; pll_lock = vecs[i].lock;
      step(vecs[i].cycles);
      chk_outs($sformatf("vec%0d", i), vecs[i].e_prst, vecs[i].e_sys, vecs[i].e_lk,
               vecs[i].e_f, vecs[i].e_r, vecs[i].e_l);
    end

    // never lock: three timed-out attempts then FAULT
    pll_lock = 1'b0;
    do_reset();
    step(3);  chk("nl.prst_hi", 32'(pll_rst), 1);
    step(1);  chk("nl.prst_lo1", 32'(pll_rst), 0);
    step(19); chk("nl.wait_lo1", 32'(pll_rst), 0); chk("nl.retry0", 32'(retry_cnt), 0);
    step(1);  chk("nl.prst_hi2", 32'(pll_rst), 1); chk("nl.retry1", 32'(retry_cnt), 1);
    step(3);  chk("nl.prst_hi2b", 32'(pll_rst), 1);
    step(1);  chk("nl.prst_lo2", 32'(pll_rst), 0);
    step(20); chk("nl.prst_hi3", 32'(pll_rst), 1); chk("nl.retry2", 32'(retry_cnt), 2);
    step(4);  chk("nl.prst_lo3", 32'(pll_rst), 0);
    step(20); chk_outs("nl.fault", 1'b1, 1'b0, 1'b0, 1'b1, 3, 0);
    step(10); chk_outs("nl.fault_hold", 1'b1, 1'b0, 1'b0, 1'b1, 3, 0);
    pulse_restart();
    chk_outs("nl.restart", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

    // glitch in STABLE: one low cycle costs a full new stable window, no retry
    pll_lock = 1'b1;
    step(9);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(3);  chk("gl.sys_early", 32'(sys_rst_n), 0); chk("gl.retry", 32'(retry_cnt), 0);
    step(7);  chk("gl.sys_late", 32'(sys_rst_n), 0);
    step(1);  chk("gl.sys_up", 32'(sys_rst_n), 1); chk("gl.locked", 32'(locked), 1);

    // restart coincident with the WAIT_LOCK timeout edge
    pll_lock = 1'b0;
    do_reset();
    step(23);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk_outs("sim.restart", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    step(3);  chk("sim.prst_hold", 32'(pll_rst), 1);
    step(1);  chk("sim.prst_fall", 32'(pll_rst), 0);
    step(19); chk("sim.retry_still0", 32'(retry_cnt), 0);
    step(1);  chk("sim.retry1", 32'(retry_cnt), 1);

    // loss counter saturation over 256 losses
    pll_lock = 1'b1;
    do_reset();
    wait_sys(1'b1, 60);
    for (int i = 0; i < 256; i++) begin
      pll_lock = 1'b0;
      wait_sys(1'b0, 10);
      if (i == 0) chk("sat.loss1", 32'(loss_cnt), 1);
      if (i == 254) chk("sat.loss255", 32'(loss_cnt), 255);
      pll_lock = 1'b1;
      wait_sys(1'b1, 60);
    end
    chk("sat.loss_hold", 32'(loss_cnt), 255);

    // restart keeps loss_cnt; rst_n beats restart mid-STABLE
    pulse_restart();
    chk_outs("rs.restart", 1'b1, 1'b0, 1'b0, 1'b0, 0, 255);
    step(7);
    chk("rs.mid_stable", 32'(sys_rst_n), 0);
    rst_n = 1'b0; restart = 1'b1;
    step(1);
    chk_outs("rs.reset", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b1; restart = 1'b0;

    // randomized asynchronous lock edges, occasional restart / reset
    begin
      int   hold;
      logic nxt;
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
        @(negedge ref_clk);
        restart = ($urandom_range(0, 299) == 0);
        rst_n   = ($urandom_range(0, 999) != 0);
        if (hold == 0) begin
          nxt  = ($urandom_range(0, 3) != 0);
          hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 120))
                                             : int'($urandom_range(1, 30));
          #($urandom_range(1, 4));
          pll_lock = nxt;
        end
        hold--;
      end
      @(negedge ref_clk);
      restart = 1'b0; rst_n = 1'b1;
      step(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
